// File: rtl/fsmd_pkg.sv
// Shared definitions for the fsmd scheduler: state encoding and default widths.
package fsmd_pkg;

  localparam int unsigned W_IN_DEFAULT  = 4;
  localparam int unsigned W_OUT_DEFAULT = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StStart = START,
    StWait  = WAIT,
    StDrain = DRAIN
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: picks a winner from req_i and holds the last-served pointer.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_val_i,
  output logic       any_o,
  output logic       win_o
);

  logic last_q;

  // Sole requester wins; on contention the client that was not served last wins.
  always_comb begin
    any_o = |req_i;
    win_o = 1'b0;
    if (req_i == 2'b10) begin
      win_o = 1'b1;
    end else if (req_i == 2'b11) begin
      win_o = ~last_q;
    end
  end

  // Last-served pointer; resets to client 1 so client 0 wins the first contention.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= upd_val_i;
    end
  end

endmodule

// File: rtl/fsmd_sched.sv
// Shares one fsmd core between two requesters: arbitrates, runs the core handshake,
// routes the result back to the owner and aborts a job whose done never arrives.
module fsmd_sched
  import fsmd_pkg::*;
#(
  parameter int unsigned W_IN    = W_IN_DEFAULT,
  parameter int unsigned W_OUT   = W_OUT_DEFAULT,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [W_IN-1:0]  xa0,
  input  logic [W_IN-1:0]  ya0,
  input  logic [W_IN-1:0]  xa1,
  input  logic [W_IN-1:0]  ya1,
  output logic             ack0,
  output logic             ack1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [W_OUT-1:0] rsp_data0,
  output logic [W_OUT-1:0] rsp_data1,
  output logic             core_start,
  output logic [W_IN-1:0]  core_xin,
  output logic [W_IN-1:0]  core_yin,
  input  logic             core_ready,
  input  logic             core_idle,
  input  logic             core_done,
  input  logic [W_OUT-1:0] core_x,
  output logic             owner,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT - 1);

  state_e             state_q;
  logic               owner_q, busy_q, timeout_err_q, core_start_q;
  logic               ack0_q, ack1_q, rsp_valid0_q, rsp_valid1_q;
  logic [W_OUT-1:0]   rsp_data0_q, rsp_data1_q;
  logic [W_IN-1:0]    xin_q, yin_q;
  logic [CNT_W-1:0]   wd_q;

  logic arb_any, arb_win, grant, active, wd_expired, last_upd;

  // Job ends (result or abort) exactly when the last-served pointer must move to the owner.
  always_comb begin
    grant      = core_ready & arb_any;
    active     = (state_q == StStart) || (state_q == StWait);
    wd_expired = (wd_q == WdLast);
    last_upd   = active & (core_done | wd_expired);
  end

  rr_arb2 u_arb (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     ({req1, req0}),
    .upd_i     (last_upd),
    .upd_val_i (owner_q),
    .any_o     (arb_any),
    .win_o     (arb_win)
  );

  // Scheduler FSM with watchdog; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      core_start_q  <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rsp_valid0_q  <= 1'b0;
      rsp_valid1_q  <= 1'b0;
      rsp_data0_q   <= '0;
      rsp_data1_q   <= '0;
      xin_q         <= '0;
      yin_q         <= '0;
      wd_q          <= '0;
    end else begin
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // An idle scheduler still reports busy while the core itself is working.
          busy_q <= ~core_idle;
          if (grant) begin
            owner_q      <= arb_win;
            xin_q        <= arb_win ? xa1 : xa0;
            yin_q        <= arb_win ? ya1 : ya0;
            ack0_q       <= ~arb_win;
            ack1_q       <= arb_win;
            wd_q         <= '0;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= StStart;
          end
        end
        StStart, StWait: begin
          if (core_done) begin
            // A done that arrives while still in START is captured directly.
            if (owner_q) begin
              rsp_data1_q  <= core_x;
              rsp_valid1_q <= 1'b1;
            end else begin
              rsp_data0_q  <= core_x;
              rsp_valid0_q <= 1'b1;
            end
            core_start_q <= 1'b0;
            state_q      <= StDrain;
          end else if (wd_expired) begin
            timeout_err_q <= 1'b1;
            core_start_q  <= 1'b0;
            state_q       <= StDrain;
          end else begin
            wd_q <= wd_q + CNT_W'(1);
            if ((state_q == StStart) && !core_ready) begin
              core_start_q <= 1'b0;
              state_q      <= StWait;
            end
          end
        end
        StDrain: begin
          // Hold off until done has dropped and the core can take a new start.
          if (!core_done && core_ready) begin
            busy_q  <= ~core_idle;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rsp_valid0  = rsp_valid0_q;
  assign rsp_valid1  = rsp_valid1_q;
  assign rsp_data0   = rsp_data0_q;
  assign rsp_data1   = rsp_data1_q;
  assign core_start  = core_start_q;
  assign core_xin    = xin_q;
  assign core_yin    = yin_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fsmd_sched.sv
// Scoreboard bench for fsmd_sched: stimulus pushes expected acks/responses, a monitor pops them.
module tb_fsmd_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] xa0 = '0, ya0 = '0, xa1 = '0, ya1 = '0;
  logic       ack0, ack1, rsp_valid0, rsp_valid1;
  logic [7:0] rsp_data0, rsp_data1;
  logic       core_start;
  logic [3:0] core_xin, core_yin;
  logic       core_ready, core_idle;
  logic       core_done = 1'b0;
  logic [7:0] core_x = '0;
  logic       owner, busy, timeout_err;

  int total = 0;
  int bad   = 0;

  fsmd_sched #(
    .W_IN    (4),
    .W_OUT   (8),
    .TIMEOUT (64),
    .CNT_W   (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .xa0         (xa0),
    .ya0         (ya0),
    .xa1         (xa1),
    .ya1         (ya1),
    .ack0        (ack0),
    .ack1        (ack1),
    .rsp_valid0  (rsp_valid0),
    .rsp_valid1  (rsp_valid1),
    .rsp_data0   (rsp_data0),
    .rsp_data1   (rsp_data1),
    .core_start  (core_start),
    .core_xin    (core_xin),
    .core_yin    (core_yin),
    .core_ready  (core_ready),
    .core_idle   (core_idle),
    .core_done   (core_done),
    .core_x      (core_x),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct packed {
    logic       c;
    logic [7:0] d;
  } rsp_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] res;
    int         lat;
    int         dlen;
    bit         hang;
  } job_t;

  int   exp_ack_q[$];
  rsp_t exp_rsp_q[$];
  job_t job_q[$];

  task automatic add_job(input logic c, input logic [3:0] x, input logic [3:0] y,
                         input logic [7:0] res, input int lat, input int dlen,
                         input bit hang, input bit want_rsp);
    job_t j;
    rsp_t r;
    j.x = x; j.y = y; j.res = res; j.lat = lat; j.dlen = dlen; j.hang = hang;
    job_q.push_back(j);
    exp_ack_q.push_back(int'(c));
    if (want_rsp) begin
      r.c = c; r.d = res;
      exp_rsp_q.push_back(r);
    end
  endtask

  // ---------------- monitor ----------------
  int   mon_c;
  rsp_t mon_r;
  always @(negedge clk) begin
    if (!rst) begin
      if (ack0 || ack1) begin
        if (exp_ack_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ack_unexpected: got ack0=%0b ack1=%0b want none", ack0, ack1);
        end else begin
          mon_c = exp_ack_q.pop_front();
          check("ack_client", 32'({ack1, ack0}), (mon_c == 1) ? 32'd2 : 32'd1);
        end
      end
      if (rsp_valid0 || rsp_valid1) begin
        check("ack_rsp_same_client", 32'((ack0 & rsp_valid0) | (ack1 & rsp_valid1)), 32'd0);
        if (exp_rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got v0=%0b v1=%0b want none", rsp_valid0, rsp_valid1);
        end else begin
          mon_r = exp_rsp_q.pop_front();
          check("rsp_client", 32'({rsp_valid1, rsp_valid0}), mon_r.c ? 32'd2 : 32'd1);
          check("rsp_data", 32'(mon_r.c ? rsp_data1 : rsp_data0), 32'(mon_r.d));
        end
      end
    end
  end

  // ---------------- core model ----------------
  typedef enum int {MIdle, MBusy, MDone} mst_e;
  mst_e mst = MIdle;
  job_t cur;
  int   mcnt, mdcnt;
  bit   hold_off = 1'b0;
  bit   abort_core = 1'b0;

  assign core_idle  = (mst == MIdle);
  assign core_ready = (mst == MIdle) && !hold_off;

  task automatic model_step();
    case (mst)
      MIdle: begin
        if (core_start && core_ready) begin
          if (job_q.size() == 0) begin
            total++; bad++;
            $display("FAIL core_start_unexpected: got xin=%0h yin=%0h want no start",
                     core_xin, core_yin);
          end else begin
            cur = job_q.pop_front();
            check("core_xin", 32'(core_xin), 32'(cur.x));
            check("core_yin", 32'(core_yin), 32'(cur.y));
            mcnt = cur.lat;
            mst  = MBusy;
          end
        end
      end
      MBusy: begin
        if (abort_core) begin
          abort_core = 1'b0;
          mst = MIdle;
        end else if (!cur.hang) begin
          if (mcnt <= 1) begin
            core_done = 1'b1;
            core_x    = cur.res;
            mdcnt     = cur.dlen;
            mst       = MDone;
          end else begin
            mcnt--;
          end
        end
      end
      MDone: begin
        mdcnt--;
        if (mdcnt <= 0) begin
          core_done = 1'b0;
          mst = MIdle;
        end
      end
      default: mst = MIdle;
    endcase
  endtask

  // Core reacts 1ns after each rising edge to the freshly registered DUT outputs.
  always begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mst = MIdle;
      core_done = 1'b0;
    end else begin
      #1;
      if (!rst) model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack0"}, 32'(ack0), 32'd0);
    check({tag, "_ack1"}, 32'(ack1), 32'd0);
    check({tag, "_rsp_valid"}, 32'({rsp_valid1, rsp_valid0}), 32'd0);
    check({tag, "_core_start"}, 32'(core_start), 32'd0);
    check({tag, "_core_ops"}, 32'({core_xin, core_yin}), 32'd0);
    check({tag, "_rsp_data0"}, 32'(rsp_data0), 32'd0);
    check({tag, "_rsp_data1"}, 32'(rsp_data1), 32'd0);
    check({tag, "_owner"}, 32'(owner), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; hold_off = 1'b0; abort_core = 1'b0;
    #1;
    check_zero(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int c, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if ((c == 1) ? ack1 : ack0) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s: got no ack%0d want ack within 100 cycles", name, c);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy && exp_rsp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s: got busy=%0b pending=%0d want idle", name, busy, exp_rsp_q.size());
    end
  endtask

  // Keeps the request level high across n acks, then drops it.
  task automatic client(input int c, input int n);
    int cnt = 0;
    for (int i = 0; i < 400 && cnt < n; i++) begin
      @(negedge clk);
      if ((c == 1) ? ack1 : ack0) cnt++;
    end
    if (cnt < n) begin
      total++; bad++;
      $display("FAIL client%0d_acks: got %0d want %0d", c, cnt, n);
    end
    tick();
    if (c == 1) req1 = 1'b0; else req0 = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int n;
  initial begin
    // 1: single job
    do_reset("rst1");
    add_job(1'b0, 4'd2, 4'd15, 8'h00, 3, 1, 1'b0, 1'b1);
    tick();
    req0 = 1'b1; xa0 = 4'd2; ya0 = 4'd15;
    wait_ack(0, "t1_ack");
    check("t1_start_hi", 32'(core_start), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_owner", 32'(owner), 32'd0);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    check("t1_start_lo", 32'(core_start), 32'd0);
    wait_idle("t1_idle");
    check("t1_busy_end", 32'(busy), 32'd0);

    // 2: contention, strict alternation 0,1,0,1
    do_reset("rst2");
    add_job(1'b0, 4'd15, 4'd2, 8'h0a, 2, 1, 1'b0, 1'b1);
    add_job(1'b1, 4'd3, 4'd15, 8'h02, 2, 1, 1'b0, 1'b1);
    add_job(1'b0, 4'd15, 4'd2, 8'h0a, 2, 1, 1'b0, 1'b1);
    add_job(1'b1, 4'd3, 4'd15, 8'h02, 2, 1, 1'b0, 1'b1);
    tick();
    req0 = 1'b1; xa0 = 4'd15; ya0 = 4'd2;
    req1 = 1'b1; xa1 = 4'd3;  ya1 = 4'd15;
    fork
      client(0, 2);
      client(1, 2);
    join
    wait_idle("t2_idle");

    // 3: core not ready holds off the grant
    hold_off = 1'b1;
    add_job(1'b1, 4'd7, 4'd9, 8'h5a, 2, 1, 1'b0, 1'b1);
    tick();
    req1 = 1'b1; xa1 = 4'd7; ya1 = 4'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_no_ack", 32'(ack1), 32'd0);
      check("t3_no_start", 32'(core_start), 32'd0);
    end
    tick();
    hold_off = 1'b0;
    @(negedge clk);
    check("t3_ack_before_ready", 32'(ack1), 32'd0);
    @(negedge clk);
    check("t3_ack_first_ready", 32'(ack1), 32'd1);
    tick();
    req1 = 1'b0;
    wait_idle("t3_idle");

    // 4: watchdog abort at 64 cycles after issue, then normal service
    add_job(1'b0, 4'd1, 4'd1, 8'h00, 1, 1, 1'b1, 1'b0);
    tick();
    req0 = 1'b1; xa0 = 4'd1; ya0 = 4'd1;
    wait_ack(0, "t4_ack");
    tick();
    req0 = 1'b0;
    @(negedge clk);
    repeat (62) @(negedge clk);
    check("t4_no_err_63", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("t4_err_64", 32'(timeout_err), 32'd1);
    check("t4_start_lo", 32'(core_start), 32'd0);
    check("t4_busy_drain", 32'(busy), 32'd1);
    abort_core = 1'b1;
    wait_idle("t4_idle_abort");
    add_job(1'b0, 4'd4, 4'd6, 8'h3c, 2, 1, 1'b0, 1'b1);
    tick();
    req0 = 1'b1; xa0 = 4'd4; ya0 = 4'd6;
    wait_ack(0, "t4_ack2");
    tick();
    req0 = 1'b0;
    wait_idle("t4_idle2");
    check("t4_err_sticky", 32'(timeout_err), 32'd1);

    // 5: done held 4 cycles, single capture, no grant until drained
    add_job(1'b0, 4'd5, 4'd5, 8'h77, 2, 4, 1'b0, 1'b1);
    add_job(1'b1, 4'd6, 4'd2, 8'h11, 2, 1, 1'b0, 1'b1);
    tick();
    req0 = 1'b1; xa0 = 4'd5; ya0 = 4'd5;
    wait_ack(0, "t5_ack0");
    tick();
    req0 = 1'b0;
    req1 = 1'b1; xa1 = 4'd6; ya1 = 4'd2;
    for (int i = 0; i < 20 && !core_done; i++) @(negedge clk);
    n = 0;
    while (core_done && n < 10) begin
      check("t5_no_ack1_done", 32'(ack1), 32'd0);
      n++;
      @(negedge clk);
    end
    check("t5_done_len", 32'(n), 32'd4);
    check("t5_no_ack1_drain", 32'(ack1), 32'd0);
    @(negedge clk);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_no_ack1_idle", 32'(ack1), 32'd0);
    @(negedge clk);
    check("t5_ack1", 32'(ack1), 32'd1);
    tick();
    req1 = 1'b0;
    wait_idle("t5_idle");

    // 6: asynchronous reset in WAIT abandons the job
    add_job(1'b0, 4'd8, 4'd3, 8'hee, 20, 1, 1'b0, 1'b0);
    tick();
    req0 = 1'b1; xa0 = 4'd8; ya0 = 4'd3;
    wait_ack(0, "t6_ack");
    tick();
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_busy_wait", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("t6_async");
    @(negedge clk);
    rst = 1'b0;
    add_job(1'b0, 4'd9, 4'd1, 8'hc3, 3, 1, 1'b0, 1'b1);
    tick();
    req0 = 1'b1; xa0 = 4'd9; ya0 = 4'd1;
    wait_ack(0, "t6_ack2");
    tick();
    req0 = 1'b0;
    wait_idle("t6_idle");
    check("t6_rsp_data0", 32'(rsp_data0), 32'hc3);

    repeat (3) @(negedge clk);
    check("end_ack_q_empty", 32'(exp_ack_q.size()), 32'd0);
    check("end_rsp_q_empty", 32'(exp_rsp_q.size()), 32'd0);
    check("end_job_q_empty", 32'(job_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/fsmd_sched.md
Name: fsmd_sched

Overview:
- Two-requester scheduler that shares one fsmd compute core between two clients.
- Arbitrates round-robin, latches the winner's 4-bit operand pair and drives the core's start/ready/done handshake.
- Captures the 8-bit result and returns it to the owning requester.
- Sits between client logic and the fsmd instance; a done watchdog guards against a hung core.

Parameters:
- W_IN, 4, operand width (core xin/yin)
- W_OUT, 8, result width (core x)
- TIMEOUT, 64, max cycles from issue to core_done before abort
- CNT_W, 7, watchdog counter width; must hold TIMEOUT

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req0 / req1  in  1  request level per client; held with operands until ack
- xa0, ya0 / xa1, ya1  in  W_IN  client operands
- ack0 / ack1  out  1  one-cycle pulse: request accepted, operands latched
- rsp_valid0 / rsp_valid1  out  1  one-cycle pulse: result valid
- rsp_data0 / rsp_data1  out  W_OUT  result; held until next response to that client
- core_start  out  1  start to fsmd core
- core_xin, core_yin  out  W_IN  operands to core
- core_ready  in  1  core can accept start
- core_idle  in  1  core idle (status only, exported via busy)
- core_done  in  1  core result valid on core_x
- core_x  in  W_OUT  core result
- owner  out  1  client currently owning the core
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- All outputs are registered.
- rst (async) forces:
  - state=IDLE; last=1, so client 0 wins first
  - all ack/rsp_valid/core_start=0; core_xin/yin=0; rsp_data*=0
  - owner=0, timeout_err=0, watchdog=0
- Reset mid-operation abandons the job with no response; the core is not re-started.
- States: IDLE, START, WAIT, DRAIN.
- IDLE:
  - Grant occurs when core_ready=1 and (req0|req1).
  - Winner: the sole requester, else the client != last.
  - On that edge: owner<=winner, core_xin/yin<=winner operands, ack_winner<=1 for one cycle, watchdog<=0, go to START.
  - No grant while core_ready=0.
- START:
  - core_start=1 is held.
  - Go to WAIT when core_ready=0 is sampled (core accepted) or core_done=1.
  - If core_done=1 on that edge, apply WAIT's done handling directly.
- WAIT:
  - core_start=0.
  - On core_done=1: rsp_data_owner<=core_x, rsp_valid_owner<=1 for one cycle, last<=owner, go to DRAIN.
- DRAIN:
  - Wait for core_done=0 and core_ready=1, then go to IDLE.
  - This prevents double capture from a multi-cycle done and prevents issuing into a busy core.
  - The earliest next grant is the cycle after DRAIN exits; minimum turnaround is accept→IDLE grant in 1 cycle after DRAIN.
- Watchdog:
  - Counts every cycle in START or WAIT.
  - At count == TIMEOUT-1 without core_done: timeout_err<=1 (sticky until rst), core_start<=0, last<=owner, go to DRAIN. No rsp_valid is issued.
- Requester rules:
  - req and operands must stay stable until ack.
  - req still high the cycle after ack is a new request.
  - A request arriving while busy waits; no queueing beyond the level req.
- Simultaneous req0&req1 alternate strictly; a lone requester can win back-to-back.
- rsp_valid0 and rsp_valid1 are never high together; ack and rsp_valid of the same client never coincide.
- Widths: operands pass through unchanged; no arithmetic is performed in this block.

Decomposition:
- Shared package fsmd_pkg:
  - state encoding constants (IDLE=2'd0, START=2'd1, WAIT=2'd2, DRAIN=2'd3)
  - W_IN/W_OUT defaults
- One sub-module: rr_arb2 (2-way round-robin winner from req[1:0] and last; combinational plus last-pointer register update enable).
- Watchdog and FSM stay in fsmd_sched.

Test Plan:
1. Single job: after rst, req0=1, xa0=2, ya0=15, core model ready, done after 3 cycles with x=8'h00 → ack0 pulse, core_start high until core_ready falls, rsp_valid0 pulse with rsp_data0=8'h00, busy back to 0 after DRAIN.
2. Contention: req0 and req1 both held (0:15,2 and 1:3,15; core returns 8'h0a then 8'h02) → grants in order 0,1,0,1; responses routed to the matching client with no rsp_valid overlap.
3. Core not ready: core_ready=0 for 10 cycles with req1=1 → no ack1, no core_start; grant on the first cycle core_ready=1 is sampled.
4. Watchdog: core never asserts done, TIMEOUT=64 → timeout_err=1 at cycle 64 after issue, core_start=0, no rsp_valid; the next request is served normally while timeout_err stays 1.
5. Long done: core_done held 4 cycles → exactly one rsp_valid pulse; no new grant until done=0 and ready=1.
6. Reset mid-WAIT: assert rst asynchronously between clock edges → outputs zero immediately, state IDLE, no response; a fresh req0 afterwards completes correctly.
